// File: rtl/ecall_uart_tx_pkg.sv
// Shared definitions for the ecall UART transmitter: FSM encodings and default constants.
// The PARITY state exists only when ECALL_UART_PARITY_EN is defined.
package ecall_uart_tx_pkg;

   localparam int   CLKS_PER_BIT_DEFAULT = 87;
   localparam int   FIFO_AW_DEFAULT      = 4;
   localparam logic UART_IDLE_LEVEL      = 1'b1;

`ifdef ECALL_UART_PARITY_EN
   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;
`else
   typedef enum logic [1:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
   } state_t;
`endif

endpackage

// File: rtl/ecall_uart_tx_byte_fifo.sv
// Synchronous byte FIFO with FIFO_AW+1 bit pointers; count is the modular pointer difference.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module byte_fifo
   import ecall_uart_tx_pkg::*;
#(
   parameter int FIFO_AW = FIFO_AW_DEFAULT
) (
   input  logic               ADC_CLK_10,
   input  logic               rst,
   input  logic               push,
   input  logic               pop,
   input  logic [7:0]         din,
   output logic [7:0]         dout,
   output logic [FIFO_AW:0]   count,
   output logic               full,
   output logic               empty
);

   localparam int DEPTH = 2 ** FIFO_AW;

   logic [7:0]       mem [DEPTH];
   logic [FIFO_AW:0] wr_ptr;
   logic [FIFO_AW:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign rd_en = pop & ~empty;
   assign wr_en = push & (~full | rd_en);

   // NOTE: storage has no reset; the pointers alone define which entries are valid.
   always_ff @(posedge ADC_CLK_10) begin
      if (wr_en) mem[wr_ptr[FIFO_AW-1:0]] <= din;
   end

   always_ff @(posedge ADC_CLK_10 or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + (FIFO_AW+1)'(1);
         if (rd_en) rd_ptr <= rd_ptr + (FIFO_AW+1)'(1);
      end
   end

   assign dout  = mem[rd_ptr[FIFO_AW-1:0]];
   assign count = wr_ptr - rd_ptr;
   assign full  = (count == (FIFO_AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/ecall_uart_tx.sv
// Ecall byte stream to UART: trigger synchroniser, byte FIFO and 8N1 serialiser on ADC_CLK_10.
// Define ECALL_UART_PARITY_EN to insert an even-parity bit between data and stop.
module ecall_uart_tx
   import ecall_uart_tx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
   parameter int FIFO_AW      = FIFO_AW_DEFAULT
) (
   input  logic               ADC_CLK_10,
   input  logic               rst,
   input  logic [7:0]         in_data,
   input  logic               in_trigger,
   input  logic               clr_overflow,
   output logic               uart_tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count,
   output logic               fifo_full,
   output logic               fifo_empty,
   output logic               overflow
);

   localparam int             BCW     = $clog2(CLKS_PER_BIT);
   localparam logic [BCW-1:0] BC_LAST = BCW'(CLKS_PER_BIT - 1);

   logic           trig_s1, trig_s2, trig_s3;
   logic           push, pop, drop;
   logic [7:0]     fifo_dout;
   state_t         state, state_n;
   logic [BCW-1:0] bc, bc_n;
   logic [2:0]     bi, bi_n;
   logic [7:0]     shreg;
   logic           tx_n;
   logic           bit_done;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge ADC_CLK_10 or posedge rst) begin
      if (rst) begin
         trig_s1 <= 1'b0;
         trig_s2 <= 1'b0;
         trig_s3 <= 1'b0;
      end else begin
         trig_s1 <= in_trigger;
         trig_s2 <= trig_s1;
         trig_s3 <= trig_s2;
      end
   end

   assign push = trig_s2 & ~trig_s3;
   assign pop  = (state == S_IDLE) & ~fifo_empty;
   assign drop = push & fifo_full & ~pop;

   byte_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
      .ADC_CLK_10 (ADC_CLK_10),
      .rst        (rst),
      .push       (push),
      .pop        (pop),
      .din        (in_data),
      .dout       (fifo_dout),
      .count      (fifo_count),
      .full       (fifo_full),
      .empty      (fifo_empty)
   );

   // A dropping push outranks a coincident clear.
   always_ff @(posedge ADC_CLK_10 or posedge rst) begin
      if (rst)               overflow <= 1'b0;
      else if (drop)         overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
   end

   always_ff @(posedge ADC_CLK_10 or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         bc      <= '0;
         bi      <= '0;
         shreg   <= '0;
         uart_tx <= UART_IDLE_LEVEL;
      end else begin
         state   <= state_n;
         bc      <= bc_n;
         bi      <= bi_n;
         uart_tx <= tx_n;
         if (pop) shreg <= fifo_dout;
      end
   end

   assign bit_done = (bc == BC_LAST);

   // NOTE: every output of this block is given a default first, so no path can infer a latch.
   always_comb begin
      state_n = state;
      bc_n    = bc;
      bi_n    = bi;
      unique case (state)
         S_IDLE: begin
            if (pop) begin
               state_n = S_START;
               bc_n    = '0;
            end
         end
         S_START: begin
            if (bit_done) begin
               state_n = S_DATA;
               bc_n    = '0;
               bi_n    = '0;
            end else begin
               bc_n = bc + BCW'(1);
            end
         end
         S_DATA: begin
            if (bit_done) begin
               bc_n = '0;
               if (bi == 3'd7) begin
`ifdef ECALL_UART_PARITY_EN
                  state_n = S_PARITY;
`else
                  state_n = S_STOP;
`endif
               end else begin
                  bi_n = bi + 3'd1;
               end
            end else begin
               bc_n = bc + BCW'(1);
            end
         end
`ifdef ECALL_UART_PARITY_EN
         S_PARITY: begin
            if (bit_done) begin
               state_n = S_STOP;
               bc_n    = '0;
            end else begin
               bc_n = bc + BCW'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_done) begin
               state_n = S_IDLE;
               bc_n    = '0;
            end else begin
               bc_n = bc + BCW'(1);
            end
         end
         default: state_n = S_IDLE;
      endcase

      // Line level is decoded from the next state so uart_tx leaves a flop aligned with it.
      tx_n = UART_IDLE_LEVEL;
      unique case (state_n)
         S_START:  tx_n = ~UART_IDLE_LEVEL;
         S_DATA:   tx_n = shreg[bi_n];
`ifdef ECALL_UART_PARITY_EN
         S_PARITY: tx_n = ^shreg;
`endif
         default:  tx_n = UART_IDLE_LEVEL;
      endcase
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_ecall_uart_tx.sv
// Randomised self-checking bench for ecall_uart_tx; a line decoder rebuilds frames from uart_tx.
// Honour ECALL_UART_PARITY_EN when compiling together with the RTL.
module tb_ecall_uart_tx;

   localparam int CPB   = 4;
   localparam int AW    = 2;
   localparam int DEPTH = 2 ** AW;
`ifdef ECALL_UART_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;

   logic          ADC_CLK_10 = 1'b0;
   logic          rst;
   logic [7:0]    in_data;
   logic          in_trigger;
   logic          clr_overflow;
   logic          uart_tx;
   logic          busy;
   logic [AW:0]   fifo_count;
   logic          fifo_full;
   logic          fifo_empty;
   logic          overflow;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_start = 0;

   typedef struct {
      logic [7:0] data;
      logic       par;
      logic       stop;
      int         start_cyc;
   } frame_t;

   frame_t     rx_q[$];
   logic [7:0] exp_q[$];

   ecall_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_AW(AW)) dut (
      .ADC_CLK_10   (ADC_CLK_10),
      .rst          (rst),
      .in_data      (in_data),
      .in_trigger   (in_trigger),
      .clr_overflow (clr_overflow),
      .uart_tx      (uart_tx),
      .busy         (busy),
      .fifo_count   (fifo_count),
      .fifo_full    (fifo_full),
      .fifo_empty   (fifo_empty),
      .overflow     (overflow)
   );

   always #5 ADC_CLK_10 = ~ADC_CLK_10;
   always @(posedge ADC_CLK_10) cyc = cyc + 1;

   // Line decoder: samples each bit in its middle, timestamps the start bit by clock edge.
   initial begin
      frame_t f;
      forever begin
         @(negedge ADC_CLK_10);
         if (rst === 1'b0 && uart_tx === 1'b0) begin
            f.start_cyc = cyc;
            last_start  = cyc;
            repeat (CPB / 2) @(negedge ADC_CLK_10);
            if (uart_tx === 1'b0) begin
               for (int i = 0; i < 8; i++) begin
                  repeat (CPB) @(negedge ADC_CLK_10);
                  f.data[i] = uart_tx;
               end
`ifdef ECALL_UART_PARITY_EN
               repeat (CPB) @(negedge ADC_CLK_10);
               f.par = uart_tx;
`else
               f.par = 1'b0;
`endif
               repeat (CPB) @(negedge ADC_CLK_10);
               f.stop = uart_tx;
               rx_q.push_back(f);
            end
         end
      end
   end

   initial begin
      repeat (60000) @(posedge ADC_CLK_10);
      $display("FAIL watchdog: simulation exceeded 60000 cycles, required completion");
      $fatal(1);
   end

   // Reference framing: start 0, data LSB first, optional even parity, stop 1.
   function automatic logic frame_bit(input logic [7:0] b, input int idx);
      if (idx == 0) return 1'b0;
      if (idx <= 8) return b[idx-1];
`ifdef ECALL_UART_PARITY_EN
      if (idx == 9) return ^b;
`endif
      return 1'b1;
   endfunction

   // Trigger pulse held for two edges; push lands on the third edge after the rise.
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge ADC_CLK_10);
      #1 in_data = b; in_trigger = 1'b1;
      repeat (2) @(posedge ADC_CLK_10);
      #1 in_trigger = 1'b0;
      @(posedge ADC_CLK_10);
      #1 in_data = 8'($urandom);
      repeat (gap) @(posedge ADC_CLK_10);
   endtask

   task automatic wait_drain(input string name);
      int n = 0;
      while (!(fifo_empty === 1'b1 && busy === 1'b0) && n < 4000) begin
         @(negedge ADC_CLK_10);
         n++;
      end
      repeat (4) @(negedge ADC_CLK_10);
      checks++;
      if (n >= 4000) begin
         errors++;
         $display("FAIL %s_drain: still busy after %0d cycles, required idle", name, n);
      end
   endtask

   task automatic test_reset();
      logic [7:0] exp_vec = {1'b1, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0};
      repeat (3) @(negedge ADC_CLK_10);
      checks++;
      if ({uart_tx, busy, fifo_count, fifo_empty, fifo_full, overflow} !== exp_vec) begin
         errors++;
         $display("FAIL reset_state: got %b required %b",
                  {uart_tx, busy, fifo_count, fifo_empty, fifo_full, overflow}, exp_vec);
      end
      rst = 1'b0;
      repeat (2) @(negedge ADC_CLK_10);
      send_byte(8'h3C, 0);
      send_byte(8'hC3, 0);
      repeat (8) @(negedge ADC_CLK_10);
      checks++;
      if (busy !== 1'b1 || fifo_count !== 3'd1) begin
         errors++;
         $display("FAIL reset_preload: busy=%b count=%0d required busy=1 count=1", busy, fifo_count);
      end
      #2 rst = 1'b1;
      #1;
      checks++;
      if ({uart_tx, busy, fifo_count, fifo_empty, fifo_full, overflow} !== exp_vec) begin
         errors++;
         $display("FAIL reset_async: got %b required %b",
                  {uart_tx, busy, fifo_count, fifo_empty, fifo_full, overflow}, exp_vec);
      end
      repeat (2) @(negedge ADC_CLK_10);
      rst = 1'b0;
      repeat (FRAME_CYC + 10) @(negedge ADC_CLK_10);
      checks++;
      if (uart_tx !== 1'b1 || busy !== 1'b0 || fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_discard: tx=%b busy=%b count=%0d required 1,0,0", uart_tx, busy, fifo_count);
      end
      rx_q.delete();
   endtask

   task automatic test_single_byte();
      logic [7:0] b = 8'hA5;
      @(posedge ADC_CLK_10);
      #1 in_data = b; in_trigger = 1'b1;
      repeat (2) @(posedge ADC_CLK_10);
      #1 in_trigger = 1'b0;
      @(posedge ADC_CLK_10);
      #1 in_data = 8'($urandom);
      @(negedge ADC_CLK_10);
      checks++;
      if (fifo_count !== 3'd1 || uart_tx !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_push_latency: count=%0d tx=%b busy=%b required 1,1,0", fifo_count, uart_tx, busy);
      end
      for (int k = 0; k < FRAME_CYC; k++) begin
         @(negedge ADC_CLK_10);
         checks++;
         if (uart_tx !== frame_bit(b, k / CPB)) begin
            errors++;
            $display("FAIL single_wave: cycle %0d tx=%b required %b", k, uart_tx, frame_bit(b, k / CPB));
         end
         if (k == 0) begin
            checks++;
            if (busy !== 1'b1 || fifo_count !== 3'd0) begin
               errors++;
               $display("FAIL single_pop: busy=%b count=%0d required 1,0", busy, fifo_count);
            end
         end
      end
      @(negedge ADC_CLK_10);
      checks++;
      if (busy !== 1'b0 || uart_tx !== 1'b1) begin
         errors++;
         $display("FAIL single_end: busy=%b tx=%b required 0,1", busy, uart_tx);
      end
      rx_q.delete();
   endtask

   task automatic test_burst();
      logic [7:0] bytes [3] = '{8'h01, 8'h02, 8'h03};
      int peak = 0;
      rx_q.delete();
      fork
         begin
            for (int i = 0; i < 3; i++) send_byte(bytes[i], 0);
         end
         begin
            repeat (20) begin
               @(negedge ADC_CLK_10);
               if (int'(fifo_count) > peak) peak = int'(fifo_count);
            end
         end
      join
      wait_drain("burst");
      checks++;
      if (peak < 2 || peak > 3) begin
         errors++;
         $display("FAIL burst_peak: peak count %0d required 2..3", peak);
      end
      checks++;
      if (fifo_count !== 3'd0) begin
         errors++;
         $display("FAIL burst_final_count: %0d required 0", fifo_count);
      end
      checks++;
      if (rx_q.size() != 3) begin
         errors++;
         $display("FAIL burst_frames: got %0d frames required 3", rx_q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            checks++;
            if (rx_q[i].data !== bytes[i] || rx_q[i].stop !== 1'b1) begin
               errors++;
               $display("FAIL burst_data[%0d]: got %h stop=%b required %h stop=1",
                        i, rx_q[i].data, rx_q[i].stop, bytes[i]);
            end
            if (i > 0) begin
               checks++;
               if (rx_q[i].start_cyc - rx_q[i-1].start_cyc != FRAME_CYC + 1) begin
                  errors++;
                  $display("FAIL burst_period[%0d]: got %0d required %0d", i,
                           rx_q[i].start_cyc - rx_q[i-1].start_cyc, FRAME_CYC + 1);
               end
            end
         end
      end
   endtask

   task automatic test_overflow();
      logic [7:0] b;
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < 6; i++) begin
         b = 8'($urandom);
         if (i < DEPTH + 1) exp_q.push_back(b);
         send_byte(b, 0);
      end
      @(negedge ADC_CLK_10);
      checks++;
      if (fifo_count !== 3'(DEPTH) || fifo_full !== 1'b1 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: count=%0d full=%b ovf=%b required %0d,1,1",
                  fifo_count, fifo_full, overflow, DEPTH);
      end
      @(posedge ADC_CLK_10);
      #1 clr_overflow = 1'b1;
      @(posedge ADC_CLK_10);
      #1 clr_overflow = 1'b0;
      @(negedge ADC_CLK_10);
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clear: ovf=%b required 0", overflow);
      end
      // Dropping push coincides with clr_overflow: the set must win.
      @(posedge ADC_CLK_10);
      #1 in_data = 8'($urandom); in_trigger = 1'b1;
      @(posedge ADC_CLK_10);
      @(posedge ADC_CLK_10);
      #1 in_trigger = 1'b0; clr_overflow = 1'b1;
      @(posedge ADC_CLK_10);
      #1 clr_overflow = 1'b0;
      @(negedge ADC_CLK_10);
      checks++;
      if (overflow !== 1'b1 || fifo_count !== 3'(DEPTH)) begin
         errors++;
         $display("FAIL overflow_set_wins: ovf=%b count=%0d required 1,%0d", overflow, fifo_count, DEPTH);
      end
      @(posedge ADC_CLK_10);
      #1 clr_overflow = 1'b1;
      @(posedge ADC_CLK_10);
      #1 clr_overflow = 1'b0;
      wait_drain("overflow");
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL overflow_frames: got %0d frames required %0d", rx_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (rx_q[i].data !== exp_q[i] || rx_q[i].stop !== 1'b1) begin
               errors++;
               $display("FAIL overflow_data[%0d]: got %h required %h", i, rx_q[i].data, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_push_pop_full();
      logic [7:0] b;
      int target;
      rx_q.delete();
      exp_q.delete();
      for (int i = 0; i < DEPTH + 1; i++) begin
         b = 8'($urandom);
         exp_q.push_back(b);
         send_byte(b, 0);
      end
      @(negedge ADC_CLK_10);
      checks++;
      if (fifo_full !== 1'b1 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL pp_fill: full=%b ovf=%b required 1,0", fifo_full, overflow);
      end
      // Raise the trigger so its push falls on the pop edge that ends the current frame.
      target = last_start + FRAME_CYC - 2;
      checks++;
      if (cyc >= target) begin
         errors++;
         $display("FAIL pp_schedule: cycle %0d already past %0d", cyc, target);
      end
      while (cyc < target) begin
         @(posedge ADC_CLK_10);
         #1;
      end
      b = 8'($urandom);
      exp_q.push_back(b);
      in_data = b; in_trigger = 1'b1;
      repeat (2) @(posedge ADC_CLK_10);
      #1 in_trigger = 1'b0;
      @(negedge ADC_CLK_10);
      checks++;
      if (busy !== 1'b0 || fifo_count !== 3'(DEPTH)) begin
         errors++;
         $display("FAIL pp_idle_gap: busy=%b count=%0d required 0,%0d", busy, fifo_count, DEPTH);
      end
      @(posedge ADC_CLK_10);
      #1 in_data = 8'($urandom);
      @(negedge ADC_CLK_10);
      checks++;
      if (fifo_count !== 3'(DEPTH) || overflow !== 1'b0 || fifo_full !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL pp_simultaneous: count=%0d ovf=%b full=%b busy=%b required %0d,0,1,1",
                  fifo_count, overflow, fifo_full, busy, DEPTH);
      end
      wait_drain("push_pop");
      checks++;
      if (rx_q.size() != exp_q.size()) begin
         errors++;
         $display("FAIL pp_frames: got %0d frames required %0d", rx_q.size(), exp_q.size());
      end else begin
         foreach (exp_q[i]) begin
            checks++;
            if (rx_q[i].data !== exp_q[i] || rx_q[i].stop !== 1'b1) begin
               errors++;
               $display("FAIL pp_data[%0d]: got %h required %h", i, rx_q[i].data, exp_q[i]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] b;
      int n;
      for (int r = 0; r < 4; r++) begin
         rx_q.delete();
         exp_q.delete();
         n = $urandom_range(2, DEPTH + 1);
         for (int i = 0; i < n; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            send_byte(b, $urandom_range(0, 3));
         end
         wait_drain("random");
         checks++;
         if (rx_q.size() != n || overflow !== 1'b0) begin
            errors++;
            $display("FAIL random_frames: round %0d got %0d frames ovf=%b required %0d,0",
                     r, rx_q.size(), overflow, n);
         end else begin
            foreach (exp_q[i]) begin
               checks++;
               if (rx_q[i].data !== exp_q[i] || rx_q[i].stop !== 1'b1) begin
                  errors++;
                  $display("FAIL random_data[%0d]: round %0d got %h required %h", i, r, rx_q[i].data, exp_q[i]);
               end
               if (i > 0) begin
                  checks++;
                  if (rx_q[i].start_cyc - rx_q[i-1].start_cyc != FRAME_CYC + 1) begin
                     errors++;
                     $display("FAIL random_period[%0d]: got %0d required %0d", i,
                              rx_q[i].start_cyc - rx_q[i-1].start_cyc, FRAME_CYC + 1);
                  end
               end
            end
         end
      end
   endtask

`ifdef ECALL_UART_PARITY_EN
   task automatic test_parity();
      logic [7:0] bytes [2] = '{8'h07, 8'h03};
      rx_q.delete();
      send_byte(bytes[0], 0);
      send_byte(bytes[1], 0);
      wait_drain("parity");
      checks++;
      if (rx_q.size() != 2) begin
         errors++;
         $display("FAIL parity_frames: got %0d required 2", rx_q.size());
      end else begin
         for (int i = 0; i < 2; i++) begin
            checks++;
            if (rx_q[i].data !== bytes[i] || rx_q[i].par !== ^bytes[i] || rx_q[i].stop !== 1'b1) begin
               errors++;
               $display("FAIL parity_bit[%0d]: data=%h par=%b required %h par=%b",
                        i, rx_q[i].data, rx_q[i].par, bytes[i], ^bytes[i]);
            end
         end
         checks++;
         if (rx_q[1].start_cyc - rx_q[0].start_cyc != FRAME_CYC + 1) begin
            errors++;
            $display("FAIL parity_period: got %0d required %0d",
                     rx_q[1].start_cyc - rx_q[0].start_cyc, FRAME_CYC + 1);
         end
      end
   endtask
`endif

   initial begin
      rst          = 1'b1;
      in_data      = 8'h00;
      in_trigger   = 1'b0;
      clr_overflow = 1'b0;
      test_reset();
      test_single_byte();
      test_burst();
      test_overflow();
      test_push_pop_full();
      test_random();
`ifdef ECALL_UART_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
